// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction-fetch stage with valid/ready handoff to decode
// and a wait-state timeout that parks the unit in a sticky error state.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    assign sum = a + b;
endmodule

module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [63:0] br_offset,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, HOLD = 3'd3, ERR = 3'd4;
    localparam logic [7:0] MW = 8'(MAX_WAIT);
    logic [2:0]  state;
    logic [63:0] pc, pc_seq, pc_br;
    logic [7:0]  wcnt, wnext;
    adder64 u_seq (.a(pc), .b(64'd4), .sum(pc_seq));
    adder64 u_br (.a(pc), .b(br_offset << 2), .sum(pc_br));
    assign wnext       = wcnt + 8'd1;
    assign imem_req    = state == REQ;
    assign instr_valid = state == HOLD;
    assign fetch_err   = state == ERR;
    assign imem_addr   = pc;
    assign instr_pc    = pc;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            wcnt        <= 8'd0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end else begin
                        wcnt  <= 8'd0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    wcnt <= wnext;
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end else if (wnext == MW) begin
                        state <= ERR;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= br_taken ? pc_br : pc_seq;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= REQ;
                    end
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed fetch sequence with an expected-instruction scoreboard.
module tb_pc_fetch_unit;
    logic        clk = 0;
    logic        reset = 1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 0;
    logic [31:0] imem_rdata = 0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 0;
    logic        br_taken = 0;
    logic [63:0] br_offset = 0;
    logic        fetch_err;
    logic [31:0] fetch_count;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] i;
        logic [63:0] p;
    } exp_t;
    exp_t q[$];
    exp_t e;

    pc_fetch_unit #(.RESET_PC(64'h1000), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_offset(br_offset), .fetch_err(fetch_err),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts in a REQ cycle; acks k cycles later and checks the resulting HOLD.
    task automatic fetch(input int k, input logic [31:0] rdata, input logic [63:0] pc);
        chk("req_strobe", {63'd0, imem_req}, 64'd1);
        chk("req_addr", imem_addr, pc);
        for (int i = 1; i <= k; i++) begin
            step();
            chk("wait_no_req", {63'd0, imem_req}, 64'd0);
            chk("wait_no_valid", {63'd0, instr_valid}, 64'd0);
        end
        imem_ack = 1;
        imem_rdata = rdata;
        q.push_back({rdata, pc});
        step();
        imem_ack = 0;
        imem_rdata = 32'h0;
        chk("valid_latency", {63'd0, instr_valid}, 64'd1);
        chk("sb_nonempty", {63'd0, q.size() != 0}, 64'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr", {32'd0, instr}, {32'd0, e.i});
            chk("instr_pc", instr_pc, e.p);
        end
    endtask

    task automatic accept(input logic taken, input logic [63:0] off, input logic [63:0] next,
                          input logic [31:0] cnt);
        instr_ready = 1;
        br_taken = taken;
        br_offset = off;
        step();
        instr_ready = 0;
        br_taken = 0;
        br_offset = 0;
        chk("next_req", {63'd0, imem_req}, 64'd1);
        chk("next_pc", imem_addr, next);
        chk("fetch_count", {32'd0, fetch_count}, {32'd0, cnt});
    endtask

    initial begin
        repeat (3) step();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_err", {63'd0, fetch_err}, 64'd0);
        chk("rst_count", {32'd0, fetch_count}, 64'd0);
        chk("rst_addr", imem_addr, 64'h1000);
        chk("rst_ipc", instr_pc, 64'h1000);
        reset = 0;
        chk("idle_no_req", {63'd0, imem_req}, 64'd0);
        step();
        fetch(0, 32'hDEAD0001, 64'h1000);
        accept(0, 64'd0, 64'h1004, 1);
        fetch(0, 32'hDEAD0002, 64'h1004);
        accept(1, -64'sd2, 64'h0FFC, 2);
        fetch(3, 32'hDEAD0003, 64'h0FFC);
        br_offset = 64'd100;
        for (int i = 0; i < 5; i++) begin
            br_taken = i[0];
            step();
            chk("bp_valid", {63'd0, instr_valid}, 64'd1);
            chk("bp_no_req", {63'd0, imem_req}, 64'd0);
            chk("bp_instr", {32'd0, instr}, 64'hDEAD0003);
            chk("bp_pc", instr_pc, 64'h0FFC);
        end
        accept(0, 64'd100, 64'h1000, 3);
        fetch(0, 32'hDEAD0004, 64'h1000);
        accept(1, -64'sd1025, 64'hFFFF_FFFF_FFFF_FFFC, 4);
        fetch(1, 32'hDEAD0005, 64'hFFFF_FFFF_FFFF_FFFC);
        accept(1, 64'hC000_0000_0000_0001, 64'h0, 5);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("to_no_req", {63'd0, imem_req}, 64'd0);
            chk("to_no_err", {63'd0, fetch_err}, 64'd0);
        end
        step();
        chk("to_err", {63'd0, fetch_err}, 64'd1);
        imem_ack = 1;
        imem_rdata = 32'hBAD0BAD0;
        repeat (2) begin
            step();
            chk("err_sticky", {63'd0, fetch_err}, 64'd1);
            chk("err_no_valid", {63'd0, instr_valid}, 64'd0);
            chk("err_no_req", {63'd0, imem_req}, 64'd0);
            chk("err_instr", {32'd0, instr}, 64'hDEAD0005);
        end
        imem_ack = 0;
        reset = 1;
        step();
        chk("clr_err", {63'd0, fetch_err}, 64'd0);
        chk("clr_count", {32'd0, fetch_count}, 64'd0);
        chk("clr_addr", imem_addr, 64'h1000);
        reset = 0;
        repeat (3) step();
        chk("mid_wait", {63'd0, imem_req | instr_valid | fetch_err}, 64'd0);
        reset = 1;
        step();
        reset = 0;
        imem_ack = 1;
        imem_rdata = 32'hBAD1BAD1;
        step();
        imem_ack = 0;
        chk("late_ack_valid", {63'd0, instr_valid}, 64'd0);
        chk("late_ack_instr", {32'd0, instr}, 64'd0);
        fetch(0, 32'h600D0001, 64'h1000);
        accept(0, 64'd0, 64'h1004, 1);
        chk("sb_empty", {32'd0, q.size()}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
